raw_scoreboard: RTL and testbench
=================================

RAW_SCOREBOARD -- requirements
Module: raw_scoreboard

Interface
REQ-001 SHALL have parameter: REG_ADDR_W, 5, register-index width (32 architectural registers).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: issue_valid  input  1  decode stage presents an instruction this cycle.
REQ-005 SHALL have port: issue_rd  input  REG_ADDR_W  destination register of the issuing instruction.
REQ-006 SHALL have port: issue_we  input  1  issuing instruction writes issue_rd.
REQ-007 SHALL have port: issue_is_load  input  1  issuing instruction is a load.
REQ-008 SHALL have ports: rs1, rs2  input  REG_ADDR_W each  source registers of the issuing instruction.
REQ-009 SHALL have ports: rs1_used, rs2_used  input  1 each  source actually read.
REQ-010 SHALL have port: flush  input  1  squash the issuing instruction and the EX slot (taken branch/jump).
REQ-011 SHALL have port: stall  output  1  hold PC and IF/ID; insert a bubble into EX.
REQ-012 SHALL have ports: fwd_a, fwd_b  output  2 each  operand select: 00 regfile, 01 EX result, 10 MEM result/load data, 11 WB data.

Function
REQ-013 SHALL track three in-flight slots (EX, MEM, WB); each slot holds valid, rd, we, is_load.
REQ-014 Slot advance per rising edge: WB<=MEM, MEM<=EX, unconditionally.
REQ-015 EX loads {issue_valid, issue_rd, issue_we, issue_is_load} when issue_valid=1, stall=0, flush=0; otherwise EX becomes a bubble (valid=0).
REQ-016 Slot "matches" rsN when slot valid=1, we=1, rd==rsN, rsN!=0, rsN_used=1.
REQ-017 fwd_a/fwd_b SHALL be combinational from current slots; priority EX (01) > MEM (10) > WB (11) > 00; youngest producer wins.
REQ-018 stall SHALL be 1 iff issue_valid=1, flush=0, and the EX slot matches rs1 or rs2 with is_load=1 (load-use); one cycle of stall per load-use.
REQ-019 While stall=1, fwd_a/fwd_b SHALL be driven 00.
REQ-020 After a load-use stall the load sits in MEM; following cycle SHALL give fwd=10 and stall=0.
REQ-021 x0 SHALL never match, stall, or forward regardless of we.
REQ-022 flush SHALL take priority over stall: stall=0, and EX bubble on next edge; MEM/WB unaffected.
REQ-023 Simultaneous match in several slots SHALL follow REQ-017 priority only; no stall for non-load matches.
REQ-024 Logic latency: stall and fwd valid in the same cycle as issue inputs; no registered outputs.

Reset
REQ-025 rst=1 SHALL asynchronously clear valid in all three slots (rd/we/is_load cleared to 0).
REQ-026 During and directly after reset, stall=0 and fwd_a=fwd_b=00.
REQ-027 Reset asserted mid-stall SHALL drop stall immediately and discard all in-flight entries.

Configuration
REQ-028 Macro RAW_STALL_COUNTER_EN: when defined, SHALL add output stall_count (32 bits) counting cycles with stall=1, cleared by rst, saturating at 2^32-1.
REQ-029 Without RAW_STALL_COUNTER_EN, stall_count port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-030 Issue add x1,x1,x2; add x1,x1,x3; add x1,x1,x4 back-to-back -> 2nd and 3rd issues fwd_a=01, fwd_b=00, stall=0 throughout; regfile x1 ends at 10.
REQ-031 lw x5,0(x0) then add x6,x5,x5 -> one cycle stall=1 with fwd 00, next cycle fwd_a=fwd_b=10, stall=0.
REQ-032 add x7,...; nop; nop; add x8,x7,x0 -> fwd_a=11 on the dependent issue; with three nops, fwd_a=00.
REQ-033 add x0,x1,x2 then add x3,x0,x0 -> fwd_a=fwd_b=00, stall=0.
REQ-034 lw x5 then add x6,x5 with flush=1 in the same cycle -> stall=0, EX bubble; assert rst mid-stall -> stall=0 within the same cycle, all fwd 00.
REQ-035 With RAW_STALL_COUNTER_EN: three separate load-use pairs -> stall_count=3; rst -> 0.

Source files
------------

// File: rtl/raw_scoreboard.sv
// RAW hazard scoreboard for a 5-stage pipeline: tracks EX/MEM/WB producers, selects
// forwarding sources and raises a one-cycle load-use stall. Optional: RAW_STALL_COUNTER_EN.
module raw_scoreboard #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic                  issue_we,
    input  logic                  issue_is_load,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic                  rs1_used,
    input  logic                  rs2_used,
    input  logic                  flush,
    output logic                  stall,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b
`ifdef RAW_STALL_COUNTER_EN
    ,
    output logic [31:0]           stall_count
`endif
);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  we;
        logic                  is_load;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '{valid: 1'b0, rd: {REG_ADDR_W{1'b0}}, we: 1'b0, is_load: 1'b0};

    slot_t ex_r;
    slot_t mem_r;
    slot_t wb_r;
    slot_t ex_next_s;
    logic  load_use_s;
    logic [1:0] sel_a_s;
    logic [1:0] sel_b_s;

    // x0 is hardwired zero, so it never has a producer worth forwarding
    function automatic logic slot_match(input slot_t s, input logic [REG_ADDR_W-1:0] rs, input logic used);
        return s.valid && s.we && used && (s.rd == rs) && (rs != {REG_ADDR_W{1'b0}});
    endfunction

    // Youngest producer wins: EX before MEM before WB
    function automatic logic [1:0] fwd_select(input slot_t ex, input slot_t mem, input slot_t wb,
                                              input logic [REG_ADDR_W-1:0] rs, input logic used);
        logic [1:0] sel;
        if (slot_match(ex, rs, used)) begin
            sel = 2'b01;
        end else if (slot_match(mem, rs, used)) begin
            sel = 2'b10;
        end else if (slot_match(wb, rs, used)) begin
            sel = 2'b11;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Hazard detection and operand selection, same cycle as the issue inputs
    always_comb begin
        load_use_s = 1'b0;
        sel_a_s    = fwd_select(ex_r, mem_r, wb_r, rs1, rs1_used);
        sel_b_s    = fwd_select(ex_r, mem_r, wb_r, rs2, rs2_used);
        if (issue_valid && !flush && ex_r.is_load) begin
            load_use_s = slot_match(ex_r, rs1, rs1_used) || slot_match(ex_r, rs2, rs2_used);
        end else begin
            load_use_s = 1'b0;
        end
        stall = load_use_s;
        if (load_use_s) begin
            fwd_a = 2'b00;
            fwd_b = 2'b00;
        end else begin
            fwd_a = sel_a_s;
            fwd_b = sel_b_s;
        end
    end

    // Next EX contents: a stalled or flushed issue leaves a bubble
    always_comb begin
        ex_next_s = SLOT_EMPTY;
        if (issue_valid && !load_use_s && !flush) begin
            ex_next_s = '{valid: 1'b1, rd: issue_rd, we: issue_we, is_load: issue_is_load};
        end else begin
            ex_next_s = SLOT_EMPTY;
        end
    end

    // In-flight slot pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_r  <= SLOT_EMPTY;
            mem_r <= SLOT_EMPTY;
            wb_r  <= SLOT_EMPTY;
        end else begin
            ex_r  <= ex_next_s;
            mem_r <= ex_r;
            wb_r  <= mem_r;
        end
    end

`ifdef RAW_STALL_COUNTER_EN
    // Saturating count of stalled cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= 32'd0;
        end else if (load_use_s && (stall_count != 32'hFFFF_FFFF)) begin
            stall_count <= stall_count + 32'd1;
        end else begin
            stall_count <= stall_count;
        end
    end
`endif

endmodule

// File: tb/tb_raw_scoreboard.sv
// Directed testbench for raw_scoreboard; builds with or without RAW_STALL_COUNTER_EN.
module tb_raw_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       issue_valid;
    logic [4:0] issue_rd;
    logic       issue_we;
    logic       issue_is_load;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1_used;
    logic       rs2_used;
    logic       flush;
    logic       stall;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
`ifdef RAW_STALL_COUNTER_EN
    logic [31:0] stall_count;
`endif

    int checks = 0;
    int errors = 0;

    raw_scoreboard #(.REG_ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_we(issue_we),
        .issue_is_load(issue_is_load), .rs1(rs1), .rs2(rs2),
        .rs1_used(rs1_used), .rs2_used(rs2_used), .flush(flush),
        .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b)
`ifdef RAW_STALL_COUNTER_EN
        , .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    // Apply one instruction and let combinational outputs settle (mid-cycle)
    task automatic drive(input logic v, input logic [4:0] rd, input logic we, input logic ld,
                         input logic [4:0] a, input logic ua, input logic [4:0] b,
                         input logic ub, input logic fl);
        issue_valid = v; issue_rd = rd; issue_we = we; issue_is_load = ld;
        rs1 = a; rs1_used = ua; rs2 = b; rs2_used = ub; flush = fl;
        #3;
    endtask

    task automatic alu(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
        drive(1'b1, rd, 1'b1, 1'b0, a, 1'b1, b, 1'b1, 1'b0);
    endtask

    task automatic load(input logic [4:0] rd);
        drive(1'b1, rd, 1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drain;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
            step();
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        alu(5'd1, 5'd1, 5'd2);
        checks++;
        if (stall !== 1'b0 || fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
            errors++;
            $display("FAIL reset_during: stall=%b fwd_a=%b fwd_b=%b, expected 0 00 00", stall, fwd_a, fwd_b);
        end
        step();
        step();
        rst = 1'b0;
        alu(5'd3, 5'd1, 5'd2);
        checks++;
        if (stall !== 1'b0 || fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
            errors++;
            $display("FAIL reset_after: stall=%b fwd_a=%b fwd_b=%b, expected 0 00 00", stall, fwd_a, fwd_b);
        end
        step();
        drain();
    endtask

    task automatic test_back_to_back;
        alu(5'd1, 5'd1, 5'd2);
        checks++;
        if (stall !== 1'b0 || fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
            errors++;
            $display("FAIL b2b_first: stall=%b fwd_a=%b fwd_b=%b, expected 0 00 00", stall, fwd_a, fwd_b);
        end
        step();
        alu(5'd1, 5'd1, 5'd3);
        checks++;
        if (stall !== 1'b0 || fwd_a !== 2'b01 || fwd_b !== 2'b00) begin
            errors++;
            $display("FAIL b2b_second: stall=%b fwd_a=%b fwd_b=%b, expected 0 01 00", stall, fwd_a, fwd_b);
        end
        step();
        alu(5'd1, 5'd1, 5'd4);
        checks++;
        if (stall !== 1'b0 || fwd_a !== 2'b01 || fwd_b !== 2'b00) begin
            errors++;
            $display("FAIL b2b_third: stall=%b fwd_a=%b fwd_b=%b, expected 0 01 00", stall, fwd_a, fwd_b);
        end
        step();
        drain();
    endtask

    task automatic test_load_use;
        load(5'd5);
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL lu_load_issue: stall=%b, expected 0", stall);
        end
        step();
        alu(5'd6, 5'd5, 5'd5);
        checks++;
        if (stall !== 1'b1 || fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
            errors++;
            $display("FAIL lu_stall: stall=%b fwd_a=%b fwd_b=%b, expected 1 00 00", stall, fwd_a, fwd_b);
        end
        step();
        alu(5'd6, 5'd5, 5'd5);
        checks++;
        if (stall !== 1'b0 || fwd_a !== 2'b10 || fwd_b !== 2'b10) begin
            errors++;
            $display("FAIL lu_release: stall=%b fwd_a=%b fwd_b=%b, expected 0 10 10", stall, fwd_a, fwd_b);
        end
        step();
        drain();
        // dependency only through rs2
        load(5'd5);
        step();
        alu(5'd6, 5'd0, 5'd5);
        checks++;
        if (stall !== 1'b1 || fwd_b !== 2'b00) begin
            errors++;
            $display("FAIL lu_rs2: stall=%b fwd_b=%b, expected 1 00", stall, fwd_b);
        end
        step();
        drain();
        // matching register that is not actually read
        load(5'd5);
        step();
        drive(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 1'b0, 5'd5, 1'b0, 1'b0);
        checks++;
        if (stall !== 1'b0 || fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
            errors++;
            $display("FAIL lu_unused: stall=%b fwd_a=%b fwd_b=%b, expected 0 00 00", stall, fwd_a, fwd_b);
        end
        step();
        drain();
    endtask

    task automatic test_wb_forward;
        alu(5'd7, 5'd1, 5'd2);
        step();
        for (int i = 0; i < 2; i++) begin
            alu(5'd0, 5'd0, 5'd0);
            step();
        end
        alu(5'd8, 5'd7, 5'd0);
        checks++;
        if (stall !== 1'b0 || fwd_a !== 2'b11 || fwd_b !== 2'b00) begin
            errors++;
            $display("FAIL wb_fwd: stall=%b fwd_a=%b fwd_b=%b, expected 0 11 00", stall, fwd_a, fwd_b);
        end
        step();
        alu(5'd7, 5'd1, 5'd2);
        step();
        for (int i = 0; i < 3; i++) begin
            alu(5'd0, 5'd0, 5'd0);
            step();
        end
        alu(5'd8, 5'd7, 5'd0);
        checks++;
        if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
            errors++;
            $display("FAIL wb_retired: fwd_a=%b fwd_b=%b, expected 00 00", fwd_a, fwd_b);
        end
        step();
        drain();
    endtask

    task automatic test_x0;
        alu(5'd0, 5'd1, 5'd2);
        step();
        alu(5'd3, 5'd0, 5'd0);
        checks++;
        if (stall !== 1'b0 || fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
            errors++;
            $display("FAIL x0_alu: stall=%b fwd_a=%b fwd_b=%b, expected 0 00 00", stall, fwd_a, fwd_b);
        end
        step();
        load(5'd0);
        step();
        alu(5'd3, 5'd0, 5'd0);
        checks++;
        if (stall !== 1'b0 || fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
            errors++;
            $display("FAIL x0_load: stall=%b fwd_a=%b fwd_b=%b, expected 0 00 00", stall, fwd_a, fwd_b);
        end
        step();
        drain();
    endtask

    task automatic test_priority;
        for (int i = 0; i < 3; i++) begin
            alu(5'd2, 5'd2, 5'd2);
            step();
        end
        alu(5'd4, 5'd2, 5'd2);
        checks++;
        if (stall !== 1'b0 || fwd_a !== 2'b01 || fwd_b !== 2'b01) begin
            errors++;
            $display("FAIL prio_ex: stall=%b fwd_a=%b fwd_b=%b, expected 0 01 01", stall, fwd_a, fwd_b);
        end
        step();
        drain();
        alu(5'd2, 5'd1, 5'd1);
        step();
        alu(5'd2, 5'd1, 5'd1);
        step();
        alu(5'd0, 5'd0, 5'd0);
        step();
        alu(5'd4, 5'd2, 5'd0);
        checks++;
        if (fwd_a !== 2'b10) begin
            errors++;
            $display("FAIL prio_mem: fwd_a=%b, expected 10", fwd_a);
        end
        step();
        drain();
        load(5'd3);
        step();
        alu(5'd3, 5'd1, 5'd1);
        step();
        alu(5'd4, 5'd3, 5'd3);
        checks++;
        if (stall !== 1'b0 || fwd_a !== 2'b01 || fwd_b !== 2'b01) begin
            errors++;
            $display("FAIL prio_young_alu: stall=%b fwd_a=%b fwd_b=%b, expected 0 01 01", stall, fwd_a, fwd_b);
        end
        step();
        drain();
    endtask

    task automatic test_flush;
        load(5'd5);
        step();
        drive(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1);
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_stall: stall=%b, expected 0", stall);
        end
        step();
        alu(5'd11, 5'd6, 5'd5);
        checks++;
        if (stall !== 1'b0 || fwd_a !== 2'b00 || fwd_b !== 2'b10) begin
            errors++;
            $display("FAIL flush_bubble: stall=%b fwd_a=%b fwd_b=%b, expected 0 00 10", stall, fwd_a, fwd_b);
        end
        step();
        drain();
        load(5'd5);
        step();
        alu(5'd6, 5'd5, 5'd5);
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_stall: stall=%b, expected 1", stall);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0 || fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid_stall: stall=%b fwd_a=%b fwd_b=%b, expected 0 00 00", stall, fwd_a, fwd_b);
        end
        step();
        rst = 1'b0;
        alu(5'd6, 5'd5, 5'd5);
        checks++;
        if (stall !== 1'b0 || fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
            errors++;
            $display("FAIL rst_discard: stall=%b fwd_a=%b fwd_b=%b, expected 0 00 00", stall, fwd_a, fwd_b);
        end
        step();
        drain();
    endtask

`ifdef RAW_STALL_COUNTER_EN
    task automatic test_stall_counter;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            load(5'd5);
            step();
            alu(5'd6, 5'd5, 5'd0);
            step();
            alu(5'd6, 5'd5, 5'd0);
            step();
            drain();
        end
        checks++;
        if (stall_count !== 32'd3) begin
            errors++;
            $display("FAIL cnt_three: stall_count=%0d, expected 3", stall_count);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (stall_count !== 32'd0) begin
            errors++;
            $display("FAIL cnt_reset: stall_count=%0d, expected 0", stall_count);
        end
        step();
        rst = 1'b0;
        step();
    endtask
`endif

    initial begin
        drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        test_reset();
        test_back_to_back();
        test_load_use();
        test_wb_forward();
        test_x0();
        test_priority();
        test_flush();
`ifdef RAW_STALL_COUNTER_EN
        test_stall_counter();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
